fifo_rd_bridge: RTL and testbench

Read-side companion for the team's synchronous FIFO. It drives the FIFO `pop` and captures the FIFO's `dout`, which is valid only during the pop cycle. It presents the captured words downstream as a registered valid/ready stream through a 2-entry output buffer. The block sits between any sync FIFO instance and a consumer that may stall, so no word is lost or duplicated under backpressure.

---
 rtl/fifo_rd_bridge.sv | 143 ++++++++++++++
 tb/tb_fifo_rd_bridge.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_rd_bridge.sv
// -----------------------------------------------------------------------------
// fifo_rd_bridge
//
// Read-side companion for the synchronous FIFO. Pops words out of the FIFO,
// captures fifo_dout in the pop cycle (the only cycle it is valid), and
// presents the words downstream as a registered valid/ready stream through a
// 2-entry buffer so that a stalling consumer never loses or duplicates a word.
//
// Parameters
//   DATA_WIDTH  width of FIFO words and stream data
//   CNT_WIDTH   width of the completed-transfer counter
//
// Ports
//   clk         single clock, rising edge
//   rstn        asynchronous active-low reset
//   fifo_empty  FIFO empty flag
//   fifo_dout   FIFO read data, valid only when fifo_pop=1 and fifo_empty=0
//   fifo_pop    pop request to the FIFO
//   flush       synchronous discard of all buffered words
//   m_valid     stream data valid
//   m_ready     consumer accepts
//   m_data      stream data (head entry)
//   occ         buffer occupancy 0..2; this is also the FSM state encoding
//   xfer_cnt    count of completed stream transfers (wraps, no saturation)
//
// Stream handshake: a word transfers on every rising edge where
// m_valid=1 and m_ready=1. Once m_valid is raised, m_valid and m_data hold
// steady until that transfer happens (or a flush discards the word);
// m_valid never depends combinationally on m_ready.
// -----------------------------------------------------------------------------
module fifo_rd_bridge #(
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  fifo_empty,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    output logic                  fifo_pop,
    input  logic                  flush,
    output logic                  m_valid,
    input  logic                  m_ready,
    output logic [DATA_WIDTH-1:0] m_data,
    output logic [1:0]            occ,
    output logic [CNT_WIDTH-1:0]  xfer_cnt
);

    // State value equals the number of buffered words, so occ is the state.
    typedef enum logic [1:0] {
        S_EMPTY = 2'd0,
        S_ONE   = 2'd1,
        S_TWO   = 2'd2
    } state_t;

    localparam logic [CNT_WIDTH-1:0] CNT_ONE = CNT_WIDTH'(1);

    state_t                r_state;
    logic                  r_valid;
    logic [CNT_WIDTH-1:0]  r_xfer_cnt;
    logic [DATA_WIDTH-1:0] r_buf0;   // head entry, drives m_data
    logic [DATA_WIDTH-1:0] r_buf1;   // second entry

    logic                  w_pop;
    logic                  w_fire;

    // Pop depends only on registered state, fifo_empty, flush and reset.
    // m_ready is deliberately absent so there is no ready-to-pop path; the
    // second buffer entry absorbs the one word popped before the stall is
    // seen. rstn gates the pop so the FIFO is never popped during reset.
    assign w_pop  = rstn & ~fifo_empty & ~flush & (r_state != S_TWO);
    assign w_fire = r_valid & m_ready;

    // Occupancy FSM with registered valid and transfer counter.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            r_state    <= S_EMPTY;
            r_valid    <= 1'b0;
            r_xfer_cnt <= '0;
        end else begin
            // A transfer that coincides with a flush still completed
            // downstream, so it is always counted.
            if (w_fire) begin
                r_xfer_cnt <= r_xfer_cnt + CNT_ONE;
            end

            if (flush) begin
                r_state <= S_EMPTY;
                r_valid <= 1'b0;
            end else begin
                case (r_state)
                    S_EMPTY: begin
                        if (w_pop) begin
                            r_state <= S_ONE;
                            r_valid <= 1'b1;
                        end
                    end
                    S_ONE: begin
                        if (!w_pop && w_fire) begin
                            r_state <= S_EMPTY;
                            r_valid <= 1'b0;
                        end else if (w_pop && !w_fire) begin
                            r_state <= S_TWO;
                            r_valid <= 1'b1;
                        end
                        // pop&fire and idle both stay in ONE
                    end
                    S_TWO: begin
                        if (w_fire) begin
                            r_state <= S_ONE;
                            r_valid <= 1'b1;
                        end
                    end
                    default: begin
                        r_state <= S_EMPTY;
                        r_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    // Data path carries no reset: contents are don't-care while the
    // corresponding entry is not occupied.
    always_ff @(posedge clk) begin
        if (w_pop && ((r_state == S_EMPTY) || ((r_state == S_ONE) && w_fire))) begin
            // Head is empty or is leaving this edge: new word becomes head.
            r_buf0 <= fifo_dout;
        end else if (w_pop && (r_state == S_ONE)) begin
            // Head is stalled: park the new word behind it.
            r_buf1 <= fifo_dout;
        end else if ((r_state == S_TWO) && w_fire) begin
            // Head left: second entry advances.
            r_buf0 <= r_buf1;
        end
    end

    assign fifo_pop = w_pop;
    assign m_valid  = r_valid;
    assign m_data   = r_buf0;
    assign occ      = r_state;
    assign xfer_cnt = r_xfer_cnt;

endmodule

// File: tb/tb_fifo_rd_bridge.sv
module tb_fifo_rd_bridge;

    localparam int DW = 32;
    localparam int CW = 4;

    logic          clk = 1'b0;
    logic          rstn;
    logic          fifo_empty;
    logic [DW-1:0] fifo_dout;
    logic          fifo_pop;
    logic          flush;
    logic          m_valid;
    logic          m_ready;
    logic [DW-1:0] m_data;
    logic [1:0]    occ;
    logic [CW-1:0] xfer_cnt;

    logic [DW-1:0] fifo_q[$];  // words held by the modelled FIFO
    logic [DW-1:0] exp_q[$];   // words expected on the stream, in order

    int checks   = 0;
    int failures = 0;
    int pops     = 0;
    int fires    = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    fifo_rd_bridge #(
        .DATA_WIDTH (DW),
        .CNT_WIDTH  (CW)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .fifo_empty (fifo_empty),
        .fifo_dout  (fifo_dout),
        .fifo_pop   (fifo_pop),
        .flush      (flush),
        .m_valid    (m_valid),
        .m_ready    (m_ready),
        .m_data     (m_data),
        .occ        (occ),
        .xfer_cnt   (xfer_cnt)
    );

    // ---------------- checking ----------------
    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic upd();
        fifo_empty = (fifo_q.size() == 0);
        fifo_dout  = fifo_empty ? 32'hDEAD_BEEF : fifo_q[0];
    endtask

    task automatic push(input logic [DW-1:0] w);
        fifo_q.push_back(w);
        upd();
    endtask

    // One clock: sample handshakes at the falling edge, score transfers,
    // then retire the popped FIFO word just after the rising edge.
    task automatic cyc();
        logic          s_pop;
        logic          s_fire;
        logic [DW-1:0] s_data;
        logic [DW-1:0] e;
        @(negedge clk);
        chk("pop_while_empty", 32'(fifo_pop & fifo_empty), 32'd0);
        s_pop  = fifo_pop & ~fifo_empty;
        s_fire = m_valid & m_ready;
        s_data = m_data;
        if (s_fire) begin
            checks++;
            assert (exp_q.size() != 0) else begin
                failures++;
                $error("FAIL unexpected_xfer observed=%0h expected=none", s_data);
            end
            if (exp_q.size() != 0) begin
                e = exp_q.pop_front();
                chk("stream_data", s_data, e);
            end
        end
        @(posedge clk);
        #1;
        if (s_pop) begin
            void'(fifo_q.pop_front());
            pops++;
            upd();
        end
        if (s_fire) fires++;
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        rstn    = 1'b0;
        flush   = 1'b0;
        m_ready = 1'b1;
        upd();

        // Reset / idle with a non-empty FIFO
        for (int i = 1; i <= 4; i++) begin
            push(32'h11 * i);
            exp_q.push_back(32'h11 * i);
        end
        repeat (2) @(posedge clk);
        #1;
        chk("rst_pop",   32'(fifo_pop), 32'd0);
        chk("rst_valid", 32'(m_valid),  32'd0);
        chk("rst_occ",   32'(occ),      32'd0);
        chk("rst_cnt",   32'(xfer_cnt), 32'd0);

        // Streaming 0x11..0x44 with m_ready held high
        rstn = 1'b1;
        #1;
        chk("first_pop",       32'(fifo_pop), 32'd1);
        chk("first_valid_low", 32'(m_valid),  32'd0);
        cyc();
        chk("first_valid", 32'(m_valid), 32'd1);
        chk("first_data",  m_data,       32'h11);
        for (int i = 1; i < 4; i++) begin
            cyc();
            chk("stream_no_gap", 32'(m_valid), 32'd1);
            chk("stream_seq",    m_data,       32'h11 * (i + 1));
        end
        cyc();
        chk("stream_valid_end", 32'(m_valid), 32'd0);
        chk("stream_occ_end",   32'(occ),     32'd0);
        chk("stream_cnt",       32'(xfer_cnt), 32'd4);
        chk("stream_drained",   32'(exp_q.size()), 32'd0);

        // Backpressure: 0xA0..0xA4 with m_ready low
        m_ready = 1'b0;
        pops    = 0;
        for (int i = 0; i < 5; i++) begin
            push(32'hA0 + i);
            exp_q.push_back(32'hA0 + i);
        end
        repeat (2) cyc();
        chk("bp_hold_data_a", m_data, 32'hA0);
        repeat (2) cyc();
        chk("bp_pops",       32'(pops),     32'd2);
        chk("bp_occ",        32'(occ),      32'd2);
        chk("bp_valid",      32'(m_valid),  32'd1);
        chk("bp_hold_data_b", m_data,       32'hA0);
        chk("bp_no_pop",     32'(fifo_pop), 32'd0);
        m_ready = 1'b1;
        repeat (5) cyc();
        chk("bp_occ_end",   32'(occ),          32'd0);
        chk("bp_cnt",       32'(xfer_cnt),     32'd9);
        chk("bp_pops_all",  32'(pops),         32'd5);
        chk("bp_drained",   32'(exp_q.size()), 32'd0);

        // Empty boundary: single word 0x5A, m_ready 0 then 1
        m_ready = 1'b0;
        pops    = 0;
        push(32'h5A);
        exp_q.push_back(32'h5A);
        cyc();
        chk("one_pops",  32'(pops),    32'd1);
        chk("one_valid", 32'(m_valid), 32'd1);
        chk("one_data",  m_data,       32'h5A);
        cyc();
        chk("one_hold_occ", 32'(occ), 32'd1);
        m_ready = 1'b1;
        cyc();
        cyc();
        chk("one_pops_end", 32'(pops),          32'd1);
        chk("one_cnt",      32'(xfer_cnt),      32'd10);
        chk("one_occ_end",  32'(occ),           32'd0);
        chk("one_drained",  32'(exp_q.size()),  32'd0);

        // Flush with occ=2 holding 0xB0,0xB1; 0xB2 waits in the FIFO
        m_ready = 1'b0;
        pops    = 0;
        push(32'hB0);
        push(32'hB1);
        push(32'hB2);
        exp_q.push_back(32'hB0);
        repeat (3) cyc();
        chk("fl_occ_pre",  32'(occ),  32'd2);
        chk("fl_data_pre", m_data,    32'hB0);
        chk("fl_pops_pre", 32'(pops), 32'd2);
        flush   = 1'b1;
        m_ready = 1'b1;
        #1;
        chk("fl_pop_cycle", 32'(fifo_pop), 32'd0);
        cyc();
        chk("fl_occ",   32'(occ),      32'd0);
        chk("fl_valid", 32'(m_valid),  32'd0);
        chk("fl_cnt",   32'(xfer_cnt), 32'd11);
        chk("fl_pop_forced", 32'(fifo_pop), 32'd0);
        cyc();
        chk("fl_pops_hold", 32'(pops), 32'd2);
        flush = 1'b0;
        exp_q.push_back(32'hB2);
        #1;
        chk("fl_resume_pop", 32'(fifo_pop), 32'd1);
        repeat (2) cyc();
        chk("fl_cnt_after", 32'(xfer_cnt),     32'd12);
        chk("fl_occ_after", 32'(occ),          32'd0);
        chk("fl_drained",   32'(exp_q.size()), 32'd0);

        // Reset mid-operation: 0xC0,0xC1 buffered are lost, 0xC2 stays in FIFO
        m_ready = 1'b0;
        pops    = 0;
        push(32'hC0);
        push(32'hC1);
        push(32'hC2);
        repeat (2) cyc();
        chk("mr_occ_pre", 32'(occ), 32'd2);
        rstn = 1'b0;
        #1;
        chk("mr_occ",   32'(occ),      32'd0);
        chk("mr_valid", 32'(m_valid),  32'd0);
        chk("mr_pop",   32'(fifo_pop), 32'd0);
        chk("mr_cnt",   32'(xfer_cnt), 32'd0);
        cyc();

        // Counter wrap at CNT_WIDTH=4: 17 transfers
        m_ready = 1'b1;
        exp_q.push_back(32'hC2);
        for (int i = 0; i < 16; i++) begin
            push(32'hD0 + i);
            exp_q.push_back(32'hD0 + i);
        end
        rstn = 1'b1;
        #1;
        chk("mr_resume_pop", 32'(fifo_pop), 32'd1);
        fires = 0;
        for (int t = 0; t < 40 && fires < 15; t++) cyc();
        chk("wrap_fires15", 32'(fires),    32'd15);
        chk("wrap_cnt15",   32'(xfer_cnt), 32'd15);
        cyc();
        chk("wrap_fires16", 32'(fires),    32'd16);
        chk("wrap_cnt16",   32'(xfer_cnt), 32'd0);
        cyc();
        chk("wrap_fires17", 32'(fires),    32'd17);
        chk("wrap_cnt17",   32'(xfer_cnt), 32'd1);
        cyc();
        chk("wrap_occ_end", 32'(occ),          32'd0);
        chk("wrap_drained", 32'(exp_q.size()), 32'd0);

        // ---------------- report ----------------
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
